// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared states, OCW2 command codes and ICW/OCW bit positions for the 8259 command sequencer
package pic_pkg;

    typedef enum logic [1:0] {
        PIC_READY = 2'd0,
        PIC_ICW2  = 2'd1,
        PIC_ICW3  = 2'd2,
        PIC_ICW4  = 2'd3
    } pic_state_e;

    // OCW2 D7..D5 = {R, SL, EOI}
    localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_S_EOI        = 3'b011;
    localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIORITY = 3'b110;
    localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;

    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

endpackage

// File: rtl/pic_command_sequencer_if.sv
// rtl/pic_command_sequencer_if.sv - decoded write flags, data byte and write-complete level from bus control
interface pic_command_sequencer_if;
    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2_4;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic       write_out;

    modport master (
        output internal_data_bus,
        output write_initial_command_word_1,
        output write_initial_command_word_2_4,
        output write_operation_control_word_2,
        output write_operation_control_word_3,
        output write_out
    );

    modport slave (
        input internal_data_bus,
        input write_initial_command_word_1,
        input write_initial_command_word_2_4,
        input write_operation_control_word_2,
        input write_operation_control_word_3,
        input write_out
    );
endinterface

// File: rtl/pic_write_commit_detect.sv
// rtl/pic_write_commit_detect.sv - sync flop plus rising-edge detector on write_out producing a one-cycle commit
module pic_write_commit_detect (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_write_out,
    output logic o_commit
);

    logic r_sync;
    logic r_prev;

    // Both flops reset high so a write_out held high across reset release is not seen as an edge
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= i_write_out;
            r_prev <= r_sync;
        end
    end

    assign o_commit = r_sync & ~r_prev;

endmodule

// File: rtl/pic_command_sequencer.sv
// rtl/pic_command_sequencer.sv - ICW init sequence, ICW/OCW registers and OCW2/OCW3 pulses; PIC_SPECIAL_MASK_EN enables special mask mode
module pic_command_sequencer
    import pic_pkg::*;
#(
    parameter logic [7:0] IMR_RESET      = 8'h00,
    parameter logic [2:0] SLAVE_ID_RESET = 3'd7
) (
    input  logic                           clock,
    input  logic                           reset_n,
    pic_command_sequencer_if.slave         bus,
    output logic                           init_busy,
    output logic                           level_trigger,
    output logic                           single_mode,
    output logic                           icw4_needed,
    output logic [4:0]                     vector_base,
    output logic [7:0]                     cascade_config,
    output logic                           auto_eoi,
    output logic                           buffered,
    output logic                           buf_master,
    output logic                           sfnm,
    output logic                           upm,
    output logic [7:0]                     interrupt_mask,
    output logic                           eoi_pulse,
    output logic                           eoi_specific,
    output logic [2:0]                     eoi_level,
    output logic                           rotate_pulse,
    output logic                           rotate_on_aeoi,
    output logic                           read_isr,
    output logic                           poll_pulse,
    output logic                           special_mask_mode
);

    pic_state_e r_state;
    pic_state_e w_next_state;

    logic       w_commit;
    logic [7:0] w_data;
    logic       w_icw1, w_icw2, w_icw3, w_icw4, w_ocw1, w_ocw2, w_ocw3;

    logic       r_level_trigger, r_single_mode, r_icw4_needed;
    logic [4:0] r_vector_base;
    logic [7:0] r_cascade_config;
    logic       r_auto_eoi, r_buffered, r_buf_master, r_sfnm, r_upm;
    logic [7:0] r_interrupt_mask;
    logic       r_eoi_pulse, r_eoi_specific, r_rotate_pulse, r_poll_pulse;
    logic [2:0] r_eoi_level;
    logic       r_rotate_on_aeoi, r_read_isr;

    pic_write_commit_detect u_commit_detect (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_write_out (bus.write_out),
        .o_commit    (w_commit)
    );

    assign w_data = bus.internal_data_bus;

    // State register for the initialization sequence
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= PIC_READY;
        else          r_state <= w_next_state;
    end

    // Classify the committed write and pick the next initialization step
    always_comb begin
        w_next_state = r_state;
        w_icw1 = 1'b0;
        w_icw2 = 1'b0;
        w_icw3 = 1'b0;
        w_icw4 = 1'b0;
        w_ocw1 = 1'b0;
        w_ocw2 = 1'b0;
        w_ocw3 = 1'b0;
        if (w_commit) begin
            if (bus.write_initial_command_word_1) begin
                w_icw1       = 1'b1;
                w_next_state = PIC_ICW2;
            end else if (bus.write_initial_command_word_2_4) begin
                case (r_state)
                    PIC_READY: w_ocw1 = 1'b1;
                    PIC_ICW2: begin
                        w_icw2 = 1'b1;
                        if (!r_single_mode)    w_next_state = PIC_ICW3;
                        else if (r_icw4_needed) w_next_state = PIC_ICW4;
                        else                   w_next_state = PIC_READY;
                    end
                    PIC_ICW3: begin
                        w_icw3       = 1'b1;
                        w_next_state = r_icw4_needed ? PIC_ICW4 : PIC_READY;
                    end
                    default: begin
                        w_icw4       = 1'b1;
                        w_next_state = PIC_READY;
                    end
                endcase
            end else if (bus.write_operation_control_word_2) begin
                w_ocw2 = (r_state == PIC_READY);
            end else if (bus.write_operation_control_word_3) begin
                w_ocw3 = (r_state == PIC_READY);
            end
        end
    end

    // Configuration registers and one-cycle command pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_level_trigger  <= 1'b0;
            r_single_mode    <= 1'b0;
            r_icw4_needed    <= 1'b0;
            r_vector_base    <= 5'd0;
            r_cascade_config <= {5'd0, SLAVE_ID_RESET};
            r_auto_eoi       <= 1'b0;
            r_buffered       <= 1'b0;
            r_buf_master     <= 1'b0;
            r_sfnm           <= 1'b0;
            r_upm            <= 1'b0;
            r_interrupt_mask <= IMR_RESET;
            r_eoi_pulse      <= 1'b0;
            r_eoi_specific   <= 1'b0;
            r_eoi_level      <= 3'd0;
            r_rotate_pulse   <= 1'b0;
            r_rotate_on_aeoi <= 1'b0;
            r_read_isr       <= 1'b0;
            r_poll_pulse     <= 1'b0;
        end else begin
            r_eoi_pulse    <= 1'b0;
            r_rotate_pulse <= 1'b0;
            r_poll_pulse   <= 1'b0;
            if (w_icw1) begin
                r_level_trigger       <= w_data[ICW1_LTIM];
                r_single_mode         <= w_data[ICW1_SNGL];
                r_icw4_needed         <= w_data[ICW1_IC4];
                r_interrupt_mask      <= IMR_RESET;
                r_cascade_config[2:0] <= SLAVE_ID_RESET;
                r_read_isr            <= 1'b0;
                r_rotate_on_aeoi      <= 1'b0;
                if (!w_data[ICW1_IC4]) begin
                    r_auto_eoi   <= 1'b0;
                    r_buffered   <= 1'b0;
                    r_buf_master <= 1'b0;
                    r_sfnm       <= 1'b0;
                    r_upm        <= 1'b0;
                end
            end
            if (w_icw2) r_vector_base    <= w_data[7:3];
            if (w_icw3) r_cascade_config <= w_data;
            if (w_icw4) begin
                r_upm        <= w_data[ICW4_UPM];
                r_auto_eoi   <= w_data[ICW4_AEOI];
                r_buf_master <= w_data[ICW4_MS];
                r_buffered   <= w_data[ICW4_BUF];
                r_sfnm       <= w_data[ICW4_SFNM];
            end
            if (w_ocw1) r_interrupt_mask <= w_data;
            if (w_ocw2) begin
                r_eoi_level <= w_data[2:0];
                case (w_data[7:5])
                    OCW2_NS_EOI:       begin r_eoi_pulse <= 1'b1; r_eoi_specific <= 1'b0; end
                    OCW2_S_EOI:        begin r_eoi_pulse <= 1'b1; r_eoi_specific <= 1'b1; end
                    OCW2_ROT_NS_EOI:   begin r_eoi_pulse <= 1'b1; r_eoi_specific <= 1'b0; r_rotate_pulse <= 1'b1; end
                    OCW2_ROT_S_EOI:    begin r_eoi_pulse <= 1'b1; r_eoi_specific <= 1'b1; r_rotate_pulse <= 1'b1; end
                    OCW2_SET_ROT_AEOI: r_rotate_on_aeoi <= 1'b1;
                    OCW2_CLR_ROT_AEOI: r_rotate_on_aeoi <= 1'b0;
                    OCW2_SET_PRIORITY: r_rotate_pulse <= 1'b1;
                    default:           ;
                endcase
            end
            if (w_ocw3) begin
                if (w_data[OCW3_P])       r_poll_pulse <= 1'b1;
                else if (w_data[OCW3_RR]) r_read_isr   <= w_data[OCW3_RIS];
            end
        end
    end

`ifdef PIC_SPECIAL_MASK_EN
    logic r_special_mask_mode;

    // Special mask mode: cleared by ICW1, loaded from SMM when ESMM is set
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                           r_special_mask_mode <= 1'b0;
        else if (w_icw1)                        r_special_mask_mode <= 1'b0;
        else if (w_ocw3 && w_data[OCW3_ESMM])   r_special_mask_mode <= w_data[OCW3_SMM];
    end

    assign special_mask_mode = r_special_mask_mode;
`else
    assign special_mask_mode = 1'b0;
`endif

    assign init_busy      = (r_state != PIC_READY);
    assign level_trigger  = r_level_trigger;
    assign single_mode    = r_single_mode;
    assign icw4_needed    = r_icw4_needed;
    assign vector_base    = r_vector_base;
    assign cascade_config = r_cascade_config;
    assign auto_eoi       = r_auto_eoi;
    assign buffered       = r_buffered;
    assign buf_master     = r_buf_master;
    assign sfnm           = r_sfnm;
    assign upm            = r_upm;
    assign interrupt_mask = r_interrupt_mask;
    assign eoi_pulse      = r_eoi_pulse;
    assign eoi_specific   = r_eoi_specific;
    assign eoi_level      = r_eoi_level;
    assign rotate_pulse   = r_rotate_pulse;
    assign rotate_on_aeoi = r_rotate_on_aeoi;
    assign read_isr       = r_read_isr;
    assign poll_pulse     = r_poll_pulse;

endmodule

// File: tb/tb_pic_command_sequencer.sv
// tb/tb_pic_command_sequencer.sv - randomized self-checking bench against a queue-based init-sequence model
module tb_pic_command_sequencer;

    localparam logic [7:0] IMR_RESET      = 8'h00;
    localparam logic [2:0] SLAVE_ID_RESET = 3'd7;

    localparam int K_ICW1 = 0;
    localparam int K_A0   = 1;
    localparam int K_OCW2 = 2;
    localparam int K_OCW3 = 3;
    localparam int K_NONE = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pic_command_sequencer_if bus_if();

    logic       init_busy, level_trigger, single_mode, icw4_needed;
    logic [4:0] vector_base;
    logic [7:0] cascade_config, interrupt_mask;
    logic       auto_eoi, buffered, buf_master, sfnm, upm;
    logic       eoi_pulse, eoi_specific, rotate_pulse, rotate_on_aeoi, read_isr, poll_pulse, special_mask_mode;
    logic [2:0] eoi_level;

    pic_command_sequencer #(.IMR_RESET(IMR_RESET), .SLAVE_ID_RESET(SLAVE_ID_RESET)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus_if.slave),
        .init_busy(init_busy), .level_trigger(level_trigger), .single_mode(single_mode),
        .icw4_needed(icw4_needed), .vector_base(vector_base), .cascade_config(cascade_config),
        .auto_eoi(auto_eoi), .buffered(buffered), .buf_master(buf_master), .sfnm(sfnm), .upm(upm),
        .interrupt_mask(interrupt_mask), .eoi_pulse(eoi_pulse), .eoi_specific(eoi_specific),
        .eoi_level(eoi_level), .rotate_pulse(rotate_pulse), .rotate_on_aeoi(rotate_on_aeoi),
        .read_isr(read_isr), .poll_pulse(poll_pulse), .special_mask_mode(special_mask_mode)
    );

    int checks = 0;
    int errors = 0;

    // Pulse monitor: counts pulses, captures qualifiers, flags any pulse lasting more than one cycle
    int n_eoi = 0, n_rot = 0, n_poll = 0, n_long = 0;
    logic [2:0] cap_lvl = 3'd0;
    logic cap_spec = 1'b0;
    logic p_eoi = 1'b0, p_rot = 1'b0, p_poll = 1'b0;
    always @(negedge clock) begin
        if (eoi_pulse === 1'b1) begin n_eoi++; cap_lvl = eoi_level; cap_spec = eoi_specific; end
        if (rotate_pulse === 1'b1) begin n_rot++; cap_lvl = eoi_level; end
        if (poll_pulse === 1'b1) n_poll++;
        if ((eoi_pulse && p_eoi) || (rotate_pulse && p_rot) || (poll_pulse && p_poll)) n_long++;
        p_eoi = eoi_pulse; p_rot = rotate_pulse; p_poll = poll_pulse;
    end

    // Reference model: pending ICWs held as a list of word numbers still owed
    int m_q[$];
    logic m_ltim, m_sngl, m_ic4, m_aeoi, m_buf, m_bm, m_sfnm, m_upm, m_raeoi, m_risr, m_smm;
    logic [4:0] m_vb;
    logic [7:0] m_casc, m_imr;
    int x_eoi, x_rot, x_poll;
    logic [2:0] x_lvl;
    logic x_spec;

    function automatic void m_reset();
        m_q.delete();
        {m_ltim, m_sngl, m_ic4, m_aeoi, m_buf, m_bm, m_sfnm, m_upm, m_raeoi, m_risr, m_smm} = '0;
        m_vb = 5'd0; m_casc = {5'd0, SLAVE_ID_RESET}; m_imr = IMR_RESET;
    endfunction

    function automatic void model_apply(input int kind, input logic [7:0] d);
        int w;
        x_eoi = 0; x_rot = 0; x_poll = 0; x_lvl = d[2:0]; x_spec = d[6];
        case (kind)
            K_ICW1: begin
                m_q.delete();
                m_q.push_back(2);
                if (!d[1]) m_q.push_back(3);
                if (d[0])  m_q.push_back(4);
                m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
                m_imr = IMR_RESET; m_casc[2:0] = SLAVE_ID_RESET;
                m_risr = 0; m_smm = 0; m_raeoi = 0;
                if (!d[0]) {m_aeoi, m_buf, m_bm, m_sfnm, m_upm} = '0;
            end
            K_A0: begin
                if (m_q.size() == 0) m_imr = d;
                else begin
                    w = m_q.pop_front();
                    if (w == 2)      m_vb = d[7:3];
                    else if (w == 3) m_casc = d;
                    else begin m_upm = d[0]; m_aeoi = d[1]; m_bm = d[2]; m_buf = d[3]; m_sfnm = d[4]; end
                end
            end
            K_OCW2: if (m_q.size() == 0) begin
                case (d[7:5])
                    3'b001, 3'b011: x_eoi = 1;
                    3'b101, 3'b111: begin x_eoi = 1; x_rot = 1; end
                    3'b110: x_rot = 1;
                    3'b100: m_raeoi = 1;
                    3'b000: m_raeoi = 0;
                    default: ;
                endcase
            end
            K_OCW3: if (m_q.size() == 0) begin
                if (d[2]) x_poll = 1;
                else if (d[1]) m_risr = d[0];
`ifdef PIC_SPECIAL_MASK_EN
                if (d[6]) m_smm = d[5];
`endif
            end
            default: ;
        endcase
    endfunction

    function automatic logic [32:0] dut_vec();
        return {init_busy, level_trigger, single_mode, icw4_needed, vector_base, cascade_config,
                auto_eoi, buffered, buf_master, sfnm, upm, interrupt_mask, rotate_on_aeoi, read_isr, special_mask_mode};
    endfunction

    function automatic logic [32:0] model_vec();
        logic busy;
        busy = (m_q.size() != 0);
        return {busy, m_ltim, m_sngl, m_ic4, m_vb, m_casc, m_aeoi, m_buf, m_bm, m_sfnm, m_upm,
                m_imr, m_raeoi, m_risr, m_smm};
    endfunction

    // One complete CPU write; returns the pulses seen during it and advances the model
    task automatic do_write(input int kind, input logic [7:0] d, output int de, output int dr, output int dp);
        int e0, r0, p0;
        e0 = n_eoi; r0 = n_rot; p0 = n_poll;
        bus_if.internal_data_bus = d;
        bus_if.write_initial_command_word_1   = (kind == K_ICW1);
        bus_if.write_initial_command_word_2_4 = (kind == K_A0);
        bus_if.write_operation_control_word_2 = (kind == K_OCW2);
        bus_if.write_operation_control_word_3 = (kind == K_OCW3);
        bus_if.write_out = 1'b1;
        repeat (4) @(negedge clock);
        bus_if.write_out = 1'b0;
        repeat (2) @(negedge clock);
        bus_if.write_initial_command_word_1   = 1'b0;
        bus_if.write_initial_command_word_2_4 = 1'b0;
        bus_if.write_operation_control_word_2 = 1'b0;
        bus_if.write_operation_control_word_3 = 1'b0;
        @(negedge clock);
        de = n_eoi - e0; dr = n_rot - r0; dp = n_poll - p0;
        model_apply(kind, d);
    endtask

    task automatic test_reset();
        logic [32:0] exp_v;
        exp_v = {4'b0, 5'd0, 5'd0, SLAVE_ID_RESET, 5'b0, IMR_RESET, 3'b0};
        checks++;
        if (dut_vec() !== exp_v) begin errors++; $display("FAIL reset_state got %h want %h", dut_vec(), exp_v); end
        checks++;
        if ({eoi_pulse, rotate_pulse, poll_pulse} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b want 000", {eoi_pulse, rotate_pulse, poll_pulse});
        end
    endtask

    task automatic test_icw_single();
        int de, dr, dp;
        do_write(K_ICW1, 8'h13, de, dr, dp);
        do_write(K_A0, 8'h08, de, dr, dp);
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid got %b want 1", init_busy); end
        do_write(K_A0, 8'h03, de, dr, dp);
        checks++;
        if ({init_busy, vector_base, auto_eoi, upm} !== {1'b0, 5'h01, 1'b1, 1'b1}) begin
            errors++; $display("FAIL single_seq got busy=%b vb=%h aeoi=%b upm=%b want 0 01 1 1", init_busy, vector_base, auto_eoi, upm);
        end
        checks++;
        if (cascade_config !== {5'd0, SLAVE_ID_RESET}) begin errors++; $display("FAIL single_no_icw3 got %h want 07", cascade_config); end
    endtask

    task automatic test_icw_cascade();
        int de, dr, dp;
        do_write(K_ICW1, 8'h11, de, dr, dp);
        do_write(K_A0, 8'h20, de, dr, dp);
        do_write(K_A0, 8'h04, de, dr, dp);
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL cascade_busy_after3 got %b want 1", init_busy); end
        do_write(K_A0, 8'h01, de, dr, dp);
        checks++;
        if ({init_busy, cascade_config, vector_base, upm} !== {1'b0, 8'h04, 5'h04, 1'b1}) begin
            errors++; $display("FAIL cascade_seq got busy=%b casc=%h vb=%h upm=%b want 0 04 04 1", init_busy, cascade_config, vector_base, upm);
        end
    endtask

    task automatic test_ocw1();
        int de, dr, dp;
        do_write(K_A0, 8'hA5, de, dr, dp);
        checks++;
        if (interrupt_mask !== 8'hA5) begin errors++; $display("FAIL ocw1_load got %h want a5", interrupt_mask); end
        do_write(K_ICW1, 8'h13, de, dr, dp);
        checks++;
        if (interrupt_mask !== IMR_RESET) begin errors++; $display("FAIL icw1_imr_reset got %h want %h", interrupt_mask, IMR_RESET); end
        do_write(K_A0, 8'h08, de, dr, dp);
        do_write(K_A0, 8'h03, de, dr, dp);
    endtask

    task automatic test_restart();
        int de, dr, dp;
        do_write(K_ICW1, 8'h11, de, dr, dp);
        do_write(K_A0, 8'h20, de, dr, dp);
        do_write(K_ICW1, 8'h13, de, dr, dp);
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", init_busy); end
        checks++;
        if (vector_base !== 5'h04) begin errors++; $display("FAIL restart_keep_vb got %h want 04", vector_base); end
        do_write(K_A0, 8'h48, de, dr, dp);
        checks++;
        if ({init_busy, vector_base} !== {1'b1, 5'h09}) begin
            errors++; $display("FAIL restart_icw2 got busy=%b vb=%h want 1 09", init_busy, vector_base);
        end
        do_write(K_OCW2, 8'h63, de, dr, dp);
        checks++;
        if (de !== 0) begin errors++; $display("FAIL ocw2_while_busy got %0d pulses want 0", de); end
        do_write(K_A0, 8'h03, de, dr, dp);
        checks++;
        if (dut_vec() !== model_vec()) begin errors++; $display("FAIL restart_final got %h want %h", dut_vec(), model_vec()); end
    endtask

    task automatic test_ocw2();
        int de, dr, dp;
        do_write(K_OCW2, 8'h63, de, dr, dp);
        checks++;
        if ({de, dr, cap_spec, cap_lvl} !== {32'd1, 32'd0, 1'b1, 3'd3}) begin
            errors++; $display("FAIL ocw2_specific_eoi got eoi=%0d rot=%0d spec=%b lvl=%0d want 1 0 1 3", de, dr, cap_spec, cap_lvl);
        end
        do_write(K_OCW2, 8'h80, de, dr, dp);
        checks++;
        if ({de, dr, rotate_on_aeoi} !== {32'd0, 32'd0, 1'b1}) begin
            errors++; $display("FAIL ocw2_set_raeoi got eoi=%0d rot=%0d raeoi=%b want 0 0 1", de, dr, rotate_on_aeoi);
        end
        do_write(K_OCW2, 8'hC5, de, dr, dp);
        checks++;
        if ({de, dr, cap_lvl} !== {32'd0, 32'd1, 3'd5}) begin
            errors++; $display("FAIL ocw2_set_priority got eoi=%0d rot=%0d lvl=%0d want 0 1 5", de, dr, cap_lvl);
        end
    endtask

    task automatic test_ocw3();
        int de, dr, dp;
        do_write(K_OCW3, 8'h0B, de, dr, dp);
        checks++;
        if (read_isr !== 1'b1) begin errors++; $display("FAIL ocw3_read_isr got %b want 1", read_isr); end
        do_write(K_OCW3, 8'h6E, de, dr, dp);
        checks++;
        if ({dp, read_isr} !== {32'd1, 1'b1}) begin
            errors++; $display("FAIL ocw3_poll_precedence got poll=%0d risr=%b want 1 1", dp, read_isr);
        end
        checks++;
        if (special_mask_mode !== m_smm) begin errors++; $display("FAIL ocw3_smm got %b want %b", special_mask_mode, m_smm); end
        do_write(K_NONE, 8'hFF, de, dr, dp);
        checks++;
        if (dut_vec() !== model_vec() || de + dr + dp != 0) begin
            errors++; $display("FAIL no_flag got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_events();
        int de, dr, dp;
        logic [32:0] exp_v;
        exp_v = {4'b0, 5'd0, 5'd0, SLAVE_ID_RESET, 5'b0, IMR_RESET, 3'b0};
        do_write(K_ICW1, 8'h1B, de, dr, dp);
        do_write(K_A0, 8'hF8, de, dr, dp);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== exp_v) begin errors++; $display("FAIL reset_mid_seq got %h want %h", dut_vec(), exp_v); end
        m_reset();
        bus_if.internal_data_bus = 8'h13;
        bus_if.write_initial_command_word_1 = 1'b1;
        bus_if.write_out = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (init_busy !== 1'b0) begin errors++; $display("FAIL release_high_commit got busy=%b want 0", init_busy); end
        bus_if.write_out = 1'b0;
        repeat (2) @(negedge clock);
        bus_if.write_out = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL release_then_edge got busy=%b want 1", init_busy); end
        bus_if.write_out = 1'b0;
        repeat (2) @(negedge clock);
        bus_if.write_initial_command_word_1 = 1'b0;
        @(negedge clock);
        model_apply(K_ICW1, 8'h13);
        do_write(K_A0, 8'h08, de, dr, dp);
        do_write(K_A0, 8'h03, de, dr, dp);
    endtask

    task automatic test_random();
        int de, dr, dp, r, kind, bad;
        logic [7:0] d;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            if (r == 0)      begin kind = K_ICW1; d[4] = 1'b1; end
            else if (r <= 4) kind = K_A0;
            else if (r <= 6) begin kind = K_OCW2; d[4:3] = 2'b00; end
            else if (r <= 8) begin kind = K_OCW3; d[4:3] = 2'b01; end
            else             kind = K_NONE;
            do_write(kind, d, de, dr, dp);
            checks++;
            if (dut_vec() !== model_vec() || de != x_eoi || dr != x_rot || dp != x_poll) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL random_%0d kind=%0d d=%h got %h p=%0d%0d%0d want %h p=%0d%0d%0d",
                                       i, kind, d, dut_vec(), de, dr, dp, model_vec(), x_eoi, x_rot, x_poll);
            end else if (x_eoi != 0 || x_rot != 0) begin
                checks++;
                if (cap_lvl !== x_lvl || (x_eoi != 0 && cap_spec !== x_spec)) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL random_qual_%0d got lvl=%0d spec=%b want lvl=%0d spec=%b", i, cap_lvl, cap_spec, x_lvl, x_spec);
                end
            end
        end
        checks++;
        if (n_long != 0) begin errors++; $display("FAIL pulse_width got %0d long pulses want 0", n_long); end
    endtask

    initial begin
        bus_if.internal_data_bus = 8'h00;
        bus_if.write_initial_command_word_1   = 1'b0;
        bus_if.write_initial_command_word_2_4 = 1'b0;
        bus_if.write_operation_control_word_2 = 1'b0;
        bus_if.write_operation_control_word_3 = 1'b0;
        bus_if.write_out = 1'b0;
        m_reset();
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        test_icw_single();
        test_icw_cascade();
        test_ocw1();
        test_restart();
        test_ocw2();
        test_ocw3();
        test_reset_events();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
